data_memory_block: RTL



---
 rtl/data_memory_block_pkg.sv | 22 ++
 rtl/mem_latency_counter.sv | 30 +++
 rtl/data_memory_block.sv | 113 +++++++++++
 3 files changed

// File: rtl/data_memory_block_pkg.sv
// Shared constants and state encoding for the block-granular data memory
// and the cache that sits in front of it.
package data_memory_block_pkg;

    localparam int BLOCK_WIDTH      = 32;
    localparam int BLOCK_ADDR_WIDTH = 6;
    localparam int BLOCK_BYTES_DEF  = 4;
    localparam int LATENCY_DEF      = 5;
    localparam int CNT_WIDTH        = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_t;

    // Counter preload so that ACCESS lasts exactly `latency` cycles.
    function automatic logic [CNT_WIDTH-1:0] latency_preload(input int latency);
        return CNT_WIDTH'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter that paces one memory access; load wins over enable
// and the zero flag is taken straight from the count register.
module mem_latency_counter
    import data_memory_block_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_enable,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/data_memory_block.sv
// Block-granular main memory behind the cache: whole-block refill and
// write-back with a fixed access latency, reported through BUSYWAIT.
module data_memory_block
    import data_memory_block_pkg::*;
#(
    parameter int ADDR_WIDTH  = BLOCK_ADDR_WIDTH,
    parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
    parameter int LATENCY     = LATENCY_DEF
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     READ,
    input  logic                     WRITE,
    input  logic [ADDR_WIDTH-1:0]    ADDRESS,
    input  logic [8*BLOCK_BYTES-1:0] WRITEDATA,
    output logic [8*BLOCK_BYTES-1:0] READDATA,
    output logic                     BUSYWAIT
);

    localparam int OFS_W     = $clog2(BLOCK_BYTES);
    localparam int BA_W      = ADDR_WIDTH + OFS_W;
    localparam int MEM_BYTES = (2 ** ADDR_WIDTH) * BLOCK_BYTES;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = latency_preload(LATENCY);

    mem_state_t               r_state;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [8*BLOCK_BYTES-1:0] r_wdata;
    logic                     r_is_write;
    logic [8*BLOCK_BYTES-1:0] r_readdata;

    logic                     w_accept;
    logic                     w_cnt_zero;
    logic                     w_finish;
    logic                     w_commit_write;
    logic [7:0]               w_mem [MEM_BYTES];
    logic [BA_W-1:0]          w_byte_idx [BLOCK_BYTES];
    logic [8*BLOCK_BYTES-1:0] w_rd_block;

    assign w_accept       = (r_state == ST_IDLE) && (READ || WRITE);
    assign w_finish       = (r_state == ST_ACCESS) && w_cnt_zero;
    assign w_commit_write = w_finish && r_is_write;

    mem_latency_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_latency_counter (
        .i_clk    (CLK),
        .i_srst   (RESET),
        .i_load   (w_accept),
        .i_value  (CNT_LOAD),
        .i_enable (r_state == ST_ACCESS),
        .o_zero   (w_cnt_zero)
    );

    // One register per byte so reset can clear the whole array in one edge.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_BYTES; gi++) begin : g_byte
            localparam logic [ADDR_WIDTH-1:0] BLK = ADDR_WIDTH'(gi / BLOCK_BYTES);
            localparam int                    K   = gi % BLOCK_BYTES;
            logic [7:0] r_byte;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_byte <= '0;
                end else if (w_commit_write && (r_addr == BLK)) begin
                    r_byte <= r_wdata[8*K +: 8];
                end
            end

            assign w_mem[gi] = r_byte;
        end

        for (gi = 0; gi < BLOCK_BYTES; gi++) begin : g_lane
            assign w_byte_idx[gi]         = {r_addr, OFS_W'(gi)};
            assign w_rd_block[8*gi +: 8]  = w_mem[w_byte_idx[gi]];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_readdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (READ || WRITE) begin
                        r_addr     <= ADDRESS;
                        r_wdata    <= WRITEDATA;
                        r_is_write <= WRITE;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (w_cnt_zero) begin
                        if (!r_is_write) begin
                            r_readdata <= w_rd_block;
                        end
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign READDATA = r_readdata;
    assign BUSYWAIT = w_accept || (r_state == ST_ACCESS);

endmodule
